// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: block-aligned Icache requests, PC/epoch
// tracking FIFO, stale-response filtering and masked block delivery.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          FETCH_WIDTH     = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fc_stall_flag_i,
  input  logic                              fc_jump_flag_i,
  input  logic [31:0]                       fc_jump_pc_i,
  output logic                              if_req_valid_o,
  output logic [31:0]                       if_req_pc_o,
  input  logic                              ic_req_ready_i,
  input  logic                              ic_rsp_valid_i,
  input  logic [32*FETCH_WIDTH-1:0]         ic_rsp_data_i,
  output logic                              if_inst_valid_o,
  output logic [31:0]                       if_inst_pc_o,
  output logic [32*FETCH_WIDTH-1:0]         if_inst_data_o,
  output logic [FETCH_WIDTH-1:0]            if_inst_mask_o,
  output logic [$clog2(MAX_OUTSTANDING):0]  if_outstanding_o
);

  localparam int BS = 4 * FETCH_WIDTH;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int FW = FETCH_WIDTH;
  localparam logic [31:0]   BMASK = ~(32'(BS) - 32'd1);
  localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {START, RUN, HOLD} state_t;

  // Slots below the entry word of a partial block are invalid.
  function automatic logic [FW-1:0] first_mask(input logic [31:0] pc);
    logic [FW-1:0] m;
    logic [31:0]   off;
    off = (pc >> 2) & 32'(FW - 1);
    for (int i = 0; i < FW; i++)
      m[i] = (32'(i) >= off);
    return m;
  endfunction

  state_t        state;
  logic          req_valid;
  logic          fresh;
  logic          epoch;
  logic [31:0]   req_pc;
  logic [FW-1:0] req_mask;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [31:0]   fifo_pc   [MAX_OUTSTANDING];
  logic [FW-1:0] fifo_mask [MAX_OUTSTANDING];
  logic          fifo_ep   [MAX_OUTSTANDING];

  logic          jump;
  logic          accept;
  logic          push;
  logic          pop;
  logic          hit;
  logic          issue;
  logic [CW-1:0] cnt_nxt;

  assign jump    = fc_jump_flag_i & (state != START);
  assign accept  = req_valid & ic_req_ready_i;
  assign pop     = ic_rsp_valid_i & (count != '0);
  assign push    = accept & ((count != MAXC) | pop);
  assign cnt_nxt = count + CW'(push) - CW'(pop);
  assign hit     = pop & (fifo_ep[rd_ptr] == epoch) & ~jump;
  assign issue   = (state != START) & ~fc_stall_flag_i
                 & (~req_valid | accept) & (cnt_nxt < MAXC);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_mask[wr_ptr] <= req_mask;
      fifo_ep[wr_ptr]   <= epoch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= START;
      req_valid       <= 1'b0;
      req_pc          <= RESET_PC & BMASK;
      req_mask        <= first_mask(RESET_PC);
      fresh           <= 1'b1;
      epoch           <= 1'b0;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      if_inst_valid_o <= 1'b0;
      if_inst_pc_o    <= '0;
      if_inst_data_o  <= '0;
      if_inst_mask_o  <= '0;
    end else begin
      count <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if_inst_valid_o <= hit;
      if (hit) begin
        if_inst_pc_o   <= fifo_pc[rd_ptr];
        if_inst_data_o <= ic_rsp_data_i;
        if_inst_mask_o <= fifo_mask[rd_ptr];
      end

      unique case (state)
        START:     state <= RUN;
        RUN, HOLD: state <= fc_stall_flag_i ? HOLD : RUN;
        default:   state <= START;
      endcase

      if (jump) begin
        epoch     <= ~epoch;
        req_valid <= 1'b1;
        req_pc    <= fc_jump_pc_i & BMASK;
        req_mask  <= first_mask(fc_jump_pc_i);
        fresh     <= 1'b0;
      end else if (issue) begin
        req_valid <= 1'b1;
        fresh     <= 1'b0;
        // A fresh address has not been issued yet, so it is sent as is.
        if (!fresh) begin
          req_pc   <= req_pc + 32'(BS);
          req_mask <= '1;
        end
      end else if (accept) begin
        req_valid <= 1'b0;
      end
    end
  end

  assign if_req_valid_o   = req_valid;
  assign if_req_pc_o      = req_pc;
  assign if_outstanding_o = count;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus
// hand-written stall, limit, simultaneous-pop and reset/wrap sequences.
module tb_if_fetch_unit;

  localparam int          FW   = 2;
  localparam int          MAXO = 4;
  localparam logic [31:0] RPC  = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jpc;
  logic        ready;
  logic        rsp_v;
  logic [63:0] rsp_d;
  logic        req_v;
  logic [31:0] req_pc;
  logic        inst_v;
  logic [31:0] inst_pc;
  logic [63:0] inst_d;
  logic [1:0]  inst_m;
  logic [2:0]  outst;

  int errs   = 0;
  int checks = 0;
  int acc;

  if_fetch_unit #(
    .RESET_PC(RPC),
    .FETCH_WIDTH(FW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fc_stall_flag_i(stall),
    .fc_jump_flag_i(jump),
    .fc_jump_pc_i(jpc),
    .if_req_valid_o(req_v),
    .if_req_pc_o(req_pc),
    .ic_req_ready_i(ready),
    .ic_rsp_valid_i(rsp_v),
    .ic_rsp_data_i(rsp_d),
    .if_inst_valid_o(inst_v),
    .if_inst_pc_o(inst_pc),
    .if_inst_data_o(inst_d),
    .if_inst_mask_o(inst_m),
    .if_outstanding_o(outst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jump;
    logic [31:0] jpc;
    logic        rdy;
    logic        rv;
    logic [63:0] d;
    logic        ev;
    logic [31:0] epc;
    logic        eiv;
    logic [31:0] eipc;
    logic [1:0]  em;
    logic [63:0] ed;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl [16];

  localparam logic [63:0] D0 = 64'h1111_0000_2222_0001;
  localparam logic [63:0] D1 = 64'h3333_0000_4444_0002;
  localparam logic [63:0] D2 = 64'h5555_0000_6666_0003;
  localparam logic [63:0] D3 = 64'hABCD_1234_5678_9ABC;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] D4 = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] D5 = 64'h0000_0005_0000_0005;
  localparam logic [63:0] D7 = 64'h7777_7777_0000_0007;

  function automatic vec_t mk(
    input logic r, s, j, input logic [31:0] p,
    input logic rd, rv, input logic [63:0] d,
    input logic ev, input logic [31:0] epc,
    input logic eiv, input logic [31:0] eipc,
    input logic [1:0] em, input logic [63:0] ed,
    input logic [2:0] ec);
    vec_t v;
    v.rst = r;  v.stall = s; v.jump = j; v.jpc = p;
    v.rdy = rd; v.rv = rv;   v.d = d;
    v.ev = ev;  v.epc = epc; v.eiv = eiv; v.eipc = eipc;
    v.em = em;  v.ed = ed;   v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, j, input logic [31:0] p,
                       input logic rd, rv, input logic [63:0] d);
    rst = r; stall = s; jump = j; jpc = p;
    ready = rd; rsp_v = rv; rsp_d = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jpc = '0;
    ready = 1'b0; rsp_v = 1'b0; rsp_d = '0;

    // boot, back-to-back issue, in-order delivery, then jump with 2 in flight
    tbl[0]  = mk(1,0,0,0,     0,0,0,  0,32'h100, 0,0,      2'b00,0,  0);
    tbl[1]  = mk(0,0,0,0,     1,0,0,  0,32'h100, 0,0,      2'b00,0,  0);
    tbl[2]  = mk(0,0,0,0,     1,0,0,  1,32'h100, 0,0,      2'b00,0,  0);
    tbl[3]  = mk(0,0,0,0,     1,0,0,  1,32'h108, 0,0,      2'b00,0,  1);
    tbl[4]  = mk(0,0,0,0,     1,0,0,  1,32'h110, 0,0,      2'b00,0,  2);
    tbl[5]  = mk(0,0,0,0,     1,1,D0, 1,32'h118, 1,32'h100,2'b11,D0, 2);
    tbl[6]  = mk(0,0,0,0,     0,1,D1, 1,32'h118, 1,32'h108,2'b11,D1, 1);
    tbl[7]  = mk(0,0,0,0,     0,1,D2, 1,32'h118, 1,32'h110,2'b11,D2, 0);
    tbl[8]  = mk(0,0,0,0,     0,0,0,  1,32'h118, 0,32'h110,2'b11,0,  0);
    tbl[9]  = mk(0,0,0,0,     1,0,0,  1,32'h120, 0,32'h110,2'b11,0,  1);
    tbl[10] = mk(0,0,0,0,     1,0,0,  1,32'h128, 0,32'h110,2'b11,0,  2);
    tbl[11] = mk(0,0,1,'h204, 0,0,0,  1,32'h200, 0,32'h110,2'b11,0,  2);
    tbl[12] = mk(0,0,0,0,     1,1,DX, 1,32'h208, 0,32'h110,2'b11,0,  2);
    tbl[13] = mk(0,0,0,0,     0,1,DX, 1,32'h208, 0,32'h110,2'b11,0,  1);
    tbl[14] = mk(0,0,0,0,     0,1,D3, 1,32'h208, 1,32'h200,2'b10,D3, 0);
    tbl[15] = mk(0,0,0,0,     0,0,0,  1,32'h208, 0,32'h200,2'b10,0,  0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].jump, tbl[i].jpc,
            tbl[i].rdy, tbl[i].rv, tbl[i].d);
      chk($sformatf("v%0d req_valid", i), 64'(req_v),   64'(tbl[i].ev));
      chk($sformatf("v%0d req_pc", i),    64'(req_pc),  64'(tbl[i].epc));
      chk($sformatf("v%0d inst_valid", i),64'(inst_v),  64'(tbl[i].eiv));
      chk($sformatf("v%0d inst_pc", i),   64'(inst_pc), 64'(tbl[i].eipc));
      chk($sformatf("v%0d inst_mask", i), 64'(inst_m),  64'(tbl[i].em));
      chk($sformatf("v%0d outstanding", i),64'(outst),  64'(tbl[i].ec));
      if (tbl[i].eiv || tbl[i].rst)
        chk($sformatf("v%0d inst_data", i), inst_d, tbl[i].ed);
    end

    // unaccepted request holds through ready=0 and a stall
    for (int i = 0; i < 5; i++) begin
      drive(0, (i >= 2), 0, 0, 0, 0, 0);
      chk($sformatf("hold%0d valid", i), 64'(req_v),  64'(1));
      chk($sformatf("hold%0d pc", i),    64'(req_pc), 64'h208);
    end
    drive(0, 1, 0, 0, 1, 0, 0);
    chk("stall accept valid", 64'(req_v), 64'(0));
    chk("stall accept count", 64'(outst), 64'(1));
    drive(0, 1, 0, 0, 1, 0, 0);
    chk("stall noissue valid", 64'(req_v), 64'(0));
    drive(0, 0, 0, 0, 0, 1, D4);
    chk("unstall valid", 64'(req_v),   64'(1));
    chk("unstall pc",    64'(req_pc),  64'h210);
    chk("unstall ipc",   64'(inst_pc), 64'h208);
    chk("unstall idata", inst_d,       D4);
    chk("unstall count", 64'(outst),   64'(0));

    // outstanding limit with no responses
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_v) acc++;
      drive(0, 0, 0, 0, 1, 0, 0);
    end
    chk("limit accepts", 64'(acc),   64'(4));
    chk("limit valid",   64'(req_v), 64'(0));
    chk("limit count",   64'(outst), 64'(4));
    drive(0, 0, 0, 0, 1, 1, D5);
    chk("reissue valid", 64'(req_v),   64'(1));
    chk("reissue pc",    64'(req_pc),  64'h120);
    chk("reissue count", 64'(outst),   64'(3));
    chk("reissue ipc",   64'(inst_pc), 64'h100);
    chk("reissue iv",    64'(inst_v),  64'(1));
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("refill valid", 64'(req_v), 64'(0));
    chk("refill count", 64'(outst), 64'(4));

    // simultaneous accept and pop at count 2, then empty-FIFO response
    drive(0, 0, 0, 0, 0, 1, D5);
    chk("pop1 pc", 64'(req_pc), 64'h128);
    drive(0, 0, 0, 0, 0, 1, D5);
    chk("pop2 count", 64'(outst),   64'(2));
    chk("pop2 ipc",   64'(inst_pc), 64'h110);
    drive(0, 0, 0, 0, 1, 1, D7);
    chk("simul count", 64'(outst),   64'(2));
    chk("simul ipc",   64'(inst_pc), 64'h118);
    chk("simul idata", inst_d,       D7);
    drive(0, 0, 0, 0, 0, 1, D5);
    drive(0, 0, 0, 0, 0, 1, D5);
    chk("drain count", 64'(outst),   64'(0));
    chk("drain ipc",   64'(inst_pc), 64'h128);
    drive(0, 0, 0, 0, 0, 1, DX);
    chk("empty rsp iv",    64'(inst_v), 64'(0));
    chk("empty rsp count", 64'(outst),  64'(0));

    // reset with 3 in flight, restart, then address wrap
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("pre-rst count", 64'(outst), 64'(3));
    drive(1, 0, 0, 0, 1, 1, DX);
    chk("rst valid", 64'(req_v),   64'(0));
    chk("rst pc",    64'(req_pc),  64'h100);
    chk("rst iv",    64'(inst_v),  64'(0));
    chk("rst ipc",   64'(inst_pc), 64'(0));
    chk("rst idata", inst_d,       64'(0));
    chk("rst imask", 64'(inst_m),  64'(0));
    chk("rst count", 64'(outst),   64'(0));
    drive(0, 0, 0, 0, 0, 1, DX);
    chk("start valid", 64'(req_v),  64'(0));
    chk("start iv",    64'(inst_v), 64'(0));
    drive(0, 0, 0, 0, 0, 1, DX);
    chk("restart valid", 64'(req_v),  64'(1));
    chk("restart pc",    64'(req_pc), 64'h100);
    chk("restart iv",    64'(inst_v), 64'(0));
    chk("restart count", 64'(outst),  64'(0));
    drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0);
    chk("wrap jump pc", 64'(req_pc), 64'hFFFF_FFF8);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("wrap pc",    64'(req_pc), 64'h0);
    chk("wrap valid", 64'(req_v),  64'(1));
    chk("wrap count", 64'(outst),  64'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
